// File: rtl/control_sequencer_if.sv
// Control-sequencer bundle: decode inputs (opcode, flags) in, bus-control strobes out.
// Latency: none; wiring only.
// Backpressure: none; strobes are levels, sampled by the datapath on each CPU clock edge.
//
// Modports:
//   master - the sequencer: consumes opcode/flags, drives step, halt and every strobe.
//   slave  - the datapath side: supplies opcode/flags, consumes the strobes.
interface control_sequencer_if #(
  parameter int STEP_WIDTH = 3
);
  logic [3:0]            i_OPCODE;
  logic                  i_FLAG_CARRY;
  logic                  i_FLAG_ZERO;
  logic [STEP_WIDTH-1:0] o_STEP;
  logic                  o_HALT;
  logic                  o_MAR_IN_n;
  logic                  o_RAM_IN;
  logic                  o_RAM_OUT_n;
  logic                  o_IR_IN_n;
  logic                  o_IR_OUT_n;
  logic                  o_A_READ_BUS_n;
  logic                  o_A_WRITE_BUS_n;
  logic                  o_B_READ_BUS_n;
  logic                  o_ALU_OUT_n;
  logic                  o_ALU_SUB;
  logic                  o_FLAGS_IN_n;
  logic                  o_OUT_READ_BUS;
  logic                  o_PC_COUNT_ENABLE;
  logic                  o_PC_WRITE_BUS;
  logic                  o_PC_JUMP_n;

  modport master (
    input  i_OPCODE, i_FLAG_CARRY, i_FLAG_ZERO,
    output o_STEP, o_HALT, o_MAR_IN_n, o_RAM_IN, o_RAM_OUT_n, o_IR_IN_n, o_IR_OUT_n,
           o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_OUT_n, o_ALU_SUB,
           o_FLAGS_IN_n, o_OUT_READ_BUS, o_PC_COUNT_ENABLE, o_PC_WRITE_BUS, o_PC_JUMP_n
  );

  modport slave (
    output i_OPCODE, i_FLAG_CARRY, i_FLAG_ZERO,
    input  o_STEP, o_HALT, o_MAR_IN_n, o_RAM_IN, o_RAM_OUT_n, o_IR_IN_n, o_IR_OUT_n,
           o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_OUT_n, o_ALU_SUB,
           o_FLAGS_IN_n, o_OUT_READ_BUS, o_PC_COUNT_ENABLE, o_PC_WRITE_BUS, o_PC_JUMP_n
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit: microstep counter + sticky halt latch, decoded into bus strobes.
// Latency: strobes are combinational from the current step/opcode/flags; state advances per edge.
// Backpressure: none; only the halt latch (cleared solely by i_CLEAR) stops the step counter.
//
// Ports:
//   i_CLOCK  - CPU clock, all state on the rising edge.
//   i_CLEAR  - synchronous active-high reset; forces every strobe inactive while high.
//   bus      - control_sequencer_if.master: opcode/flags in, o_STEP/o_HALT/strobes out.
// Build option:
//   XDN_EARLY_STEP_RESET_EN - when defined, the step counter returns to T0 right after the
//   last active step of each instruction instead of running through idle steps.
module control_sequencer #(
  parameter int STEP_COUNT = 5,
  parameter int STEP_WIDTH = 3
) (
  input  logic                 i_CLOCK,
  input  logic                 i_CLEAR,
  control_sequencer_if.master  bus
);

  localparam logic [STEP_WIDTH-1:0] T0        = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] T1        = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] T2        = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] T3        = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] T4        = STEP_WIDTH'(4);
  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(STEP_COUNT - 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Active-high view of the control word; polarity is fixed up at the port assigns.
  typedef struct packed {
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_read;
    logic a_write;
    logic b_read;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_read;
    logic pc_count;
    logic pc_write;
    logic pc_jump;
    logic halt;
  } ctrl_t;

  logic [STEP_WIDTH-1:0] step_q;
  logic                  halt_q;
  ctrl_t                 ctrl;

  always_comb begin
    ctrl = '0;
    if (i_CLEAR) begin
      ctrl = '0;
    end else if (halt_q) begin
      ctrl.halt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl.pc_write = 1'b1;
          ctrl.mar_in   = 1'b1;
        end
        T1: begin
          ctrl.ram_out  = 1'b1;
          ctrl.ir_in    = 1'b1;
          ctrl.pc_count = 1'b1;
        end
        T2: begin
          case (bus.i_OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_out = 1'b1;
              ctrl.mar_in = 1'b1;
            end
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_read = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_jump = 1'b1;
            end
            // Conditional jumps still put the operand on the bus; only the load is gated.
            OP_JC: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_jump = bus.i_FLAG_CARRY;
            end
            OP_JZ: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_jump = bus.i_FLAG_ZERO;
            end
            OP_OUT: begin
              ctrl.a_write  = 1'b1;
              ctrl.out_read = 1'b1;
            end
            OP_HLT: ctrl.halt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (bus.i_OPCODE)
            OP_LDA: begin
              ctrl.ram_out = 1'b1;
              ctrl.a_read  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_read  = 1'b1;
            end
            OP_STA: begin
              ctrl.a_write = 1'b1;
              ctrl.ram_in  = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (bus.i_OPCODE == OP_ADD || bus.i_OPCODE == OP_SUB) begin
            ctrl.alu_out  = 1'b1;
            ctrl.a_read   = 1'b1;
            ctrl.flags_in = 1'b1;
            ctrl.alu_sub  = (bus.i_OPCODE == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XDN_EARLY_STEP_RESET_EN
  logic [STEP_WIDTH-1:0] last_step;
  always_comb begin
    case (bus.i_OPCODE)
      OP_NOP:         last_step = T1;
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
  end
  wire at_last = (step_q == last_step);
`else
  wire at_last = 1'b0;
`endif

  // Halt latch sets at the end of T2 of HLT and the step is left frozen at T2.
  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else if (!halt_q) begin
      if (ctrl.halt) begin
        halt_q <= 1'b1;
      end else if (at_last || step_q == STEP_LAST) begin
        step_q <= T0;
      end else begin
        step_q <= step_q + T1;
      end
    end
  end

  assign bus.o_STEP            = step_q;
  assign bus.o_HALT            = ctrl.halt;
  assign bus.o_MAR_IN_n        = ~ctrl.mar_in;
  assign bus.o_RAM_IN          = ctrl.ram_in;
  assign bus.o_RAM_OUT_n       = ~ctrl.ram_out;
  assign bus.o_IR_IN_n         = ~ctrl.ir_in;
  assign bus.o_IR_OUT_n        = ~ctrl.ir_out;
  assign bus.o_A_READ_BUS_n    = ~ctrl.a_read;
  assign bus.o_A_WRITE_BUS_n   = ~ctrl.a_write;
  assign bus.o_B_READ_BUS_n    = ~ctrl.b_read;
  assign bus.o_ALU_OUT_n       = ~ctrl.alu_out;
  assign bus.o_ALU_SUB         = ctrl.alu_sub;
  assign bus.o_FLAGS_IN_n      = ~ctrl.flags_in;
  assign bus.o_OUT_READ_BUS    = ctrl.out_read;
  assign bus.o_PC_COUNT_ENABLE = ctrl.pc_count;
  assign bus.o_PC_WRITE_BUS    = ctrl.pc_write;
  assign bus.o_PC_JUMP_n       = ~ctrl.pc_jump;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU; sits directly upstream of the program counter, A/B registers and output module and drives their bus-control strobes.
- Holds a microstep counter (T0..T4) and a sticky halt latch. Decodes the instruction-register opcode plus ALU flags into one control word per step.

Parameters:
- STEP_COUNT, 5, number of microsteps per instruction (T0..STEP_COUNT-1); must be ≥5.
- STEP_WIDTH, 3, width of step counter; must hold STEP_COUNT-1.

Ports:
- i_CLOCK  in  1  CPU clock (gated clock from clock module); all state on rising edge.
- i_CLEAR  in  1  reset, synchronous, active-high.
- i_OPCODE  in  4  upper nibble of instruction register; valid from T2 onward.
- i_FLAG_CARRY  in  1  registered ALU carry flag.
- i_FLAG_ZERO  in  1  registered ALU zero flag.
- o_STEP  out  STEP_WIDTH  current microstep, for debug display.
- o_HALT  out  1  request clock module to stop.
- o_MAR_IN_n  out  1  memory address register loads bus (active-low).
- o_RAM_IN  out  1  RAM writes bus.
- o_RAM_OUT_n  out  1  RAM drives bus (active-low).
- o_IR_IN_n  out  1  instruction register loads bus (active-low).
- o_IR_OUT_n  out  1  IR operand nibble drives bus (active-low).
- o_A_READ_BUS_n  out  1  A register loads bus (active-low).
- o_A_WRITE_BUS_n  out  1  A register drives bus (active-low).
- o_B_READ_BUS_n  out  1  B register loads bus (active-low).
- o_ALU_OUT_n  out  1  ALU drives bus (active-low).
- o_ALU_SUB  out  1  ALU subtract select.
- o_FLAGS_IN_n  out  1  flags register loads (active-low).
- o_OUT_READ_BUS  out  1  output module loads bus.
- o_PC_COUNT_ENABLE  out  1  PC increments.
- o_PC_WRITE_BUS  out  1  PC drives bus.
- o_PC_JUMP_n  out  1  PC loads bus (active-low).

Behaviour:
- State consists of the step counter and the halt latch. Control outputs are combinational from (step, opcode, flags, halt latch, i_CLEAR).
- Inactive levels: active-low strobes = 1; active-high strobes = 0.
- Reset: while i_CLEAR=1, all control outputs are inactive and o_HALT=0. At the edge, step←0 and halt←0. The first post-reset cycle presents T0.
- Step counter: increments each edge and wraps STEP_COUNT-1→0.
- Fetch (every opcode):
  - T0: PC_WRITE_BUS, MAR_IN.
  - T1: RAM_OUT, IR_IN, PC_COUNT_ENABLE.
- Execute:
  - 0x0 NOP: nothing.
  - 0x1 LDA: T2 IR_OUT+MAR_IN; T3 RAM_OUT+A_READ.
  - 0x2 ADD: T2 IR_OUT+MAR_IN; T3 RAM_OUT+B_READ; T4 ALU_OUT+A_READ+FLAGS_IN.
  - 0x3 SUB: as ADD, plus ALU_SUB on T4.
  - 0x4 STA: T2 IR_OUT+MAR_IN; T3 A_WRITE+RAM_IN.
  - 0x5 LDI: T2 IR_OUT+A_READ.
  - 0x6 JMP: T2 IR_OUT+PC_JUMP.
  - 0x7 JC: T2 IR_OUT, plus PC_JUMP only if i_FLAG_CARRY=1 (sampled combinationally during T2).
  - 0x8 JZ: as JC, using i_FLAG_ZERO.
  - 0xE OUT: T2 A_WRITE+OUT_READ_BUS.
  - 0xF HLT: T2 o_HALT=1 combinationally; halt latch sets at the end of T2.
  - 0x9–0xD: behave as NOP.
- Halted (latch=1):
  - o_HALT=1, all other controls inactive, step frozen.
  - Only i_CLEAR exits the halted state.
- Bus drivers: in every step, at most one of RAM_OUT, IR_OUT, A_WRITE, ALU_OUT, PC_WRITE_BUS is active.
- Reset mid-instruction: takes effect at the next edge regardless of step. Halt has no priority over reset.
- Opcode changes between steps (IR load at T1): decoding always uses the current i_OPCODE, so T0/T1 are opcode-independent.

Optional Feature:
- Macro: XDN_EARLY_STEP_RESET_EN.
- Defined: at the last active step of each instruction, step←0 at the next edge instead of incrementing.
  - Last steps: NOP T1; LDA/STA T3; ADD/SUB T4; LDI/JMP/JC/JZ/OUT and undefined opcodes T2.
  - This shortens the instruction; no extra idle cycle is inserted.
- Undefined: the counter always runs the full T0..STEP_COUNT-1 sequence, with idle (all-inactive) steps after execute.

Test Plan:
- Reset: hold i_CLEAR for 2 edges with opcode 0x2 → all strobes inactive during reset; after release o_STEP=0, o_PC_WRITE_BUS=1, o_MAR_IN_n=0.
- ADD sequence (opcode 0x2) → T2 o_IR_OUT_n=0/o_MAR_IN_n=0; T3 o_RAM_OUT_n=0/o_B_READ_BUS_n=0; T4 o_ALU_OUT_n=0/o_A_READ_BUS_n=0/o_FLAGS_IN_n=0, o_ALU_SUB=0; SUB (0x3) identical but o_ALU_SUB=1 at T4.
- JC with carry=0 then carry=1 → o_PC_JUMP_n stays 1 in the first case and is 0 at T2 in the second; JZ likewise with zero.
- HLT (0xF) → o_HALT=1 at T2, o_STEP stays 2 for ≥10 edges, all other strobes inactive; assert i_CLEAR → o_HALT=0 and o_STEP=0 next cycle.
- Early reset (macro defined): LDI, LDA, ADD back-to-back → o_STEP sequences 0,1,2 / 0,1,2,3 / 0,1,2,3,4. Without the macro, each instruction takes 5 steps.
- Random opcodes/flags for 1000 cycles → bus-driver exclusivity assertion never fires; undefined opcodes 0x9–0xD produce no execute strobes.
